// File: rtl/io_port_arbiter.sv
// io_port_arbiter: shares the io block's single load/store port between
// requester A (core datapath) and requester B (debug/DMA loader).
// One access is in flight at a time; the winner is chosen by round-robin
// (RR=1) or fixed A-first priority (RR=0). Load data is captured LOAD_LAT
// cycles after the en_load cycle and returned with a one-cycle rvalid.
// Ports:
//   clk, rst                        clock, async active-high reset
//   a_req/a_we/a_addr/a_wdata       requester A access request
//   a_gnt, a_rvalid                 A issue pulse, A load-data-valid pulse
//   b_*                             same as A, for requester B
//   rd_data                         captured load data (shared)
//   en_store/addr_store/data_store  io store lines
//   en_load/addr_load, data_load    io load lines and returned load data
//   busy                            high whenever not idle
module io_port_arbiter #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned RR       = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] rd_data,
  output logic              en_store,
  output logic [ADDR_W-1:0] addr_store,
  output logic [DATA_W-1:0] data_store,
  output logic              en_load,
  output logic [ADDR_W-1:0] addr_load,
  input  logic [DATA_W-1:0] data_load,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;
  // WAIT runs LOAD_LAT cycles, counting down to zero.
  localparam logic [1:0] LAT_INIT = (LOAD_LAT > 0) ? 2'(LOAD_LAT - 1) : 2'd0;

  state_e              state_q, state_d;
  logic [1:0]          lat_q, lat_d;
  logic                owner_q, owner_d;
  logic                last_q, last_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                winner;

  logic                a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
  logic                a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic                en_store_q, en_store_d, en_load_q, en_load_d;
  logic [ADDR_W-1:0]   addr_store_q, addr_store_d, addr_load_q, addr_load_d;
  logic [DATA_W-1:0]   data_store_q, data_store_d;
  logic                busy_q, busy_d;

  // State register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      lat_q        <= 2'd0;
      owner_q      <= OWN_A;
      last_q       <= OWN_B;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_data_q    <= '0;
      a_gnt_q      <= 1'b0;
      b_gnt_q      <= 1'b0;
      a_rvalid_q   <= 1'b0;
      b_rvalid_q   <= 1'b0;
      en_store_q   <= 1'b0;
      en_load_q    <= 1'b0;
      addr_store_q <= '0;
      addr_load_q  <= '0;
      data_store_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_q        <= lat_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rd_data_q    <= rd_data_d;
      a_gnt_q      <= a_gnt_d;
      b_gnt_q      <= b_gnt_d;
      a_rvalid_q   <= a_rvalid_d;
      b_rvalid_q   <= b_rvalid_d;
      en_store_q   <= en_store_d;
      en_load_q    <= en_load_d;
      addr_store_q <= addr_store_d;
      addr_load_q  <= addr_load_d;
      data_store_q <= data_store_d;
      busy_q       <= busy_d;
    end
  end

  // Next state, arbitration and next-cycle output decode.
  always_comb begin
    state_d      = state_q;
    lat_d        = lat_q;
    owner_d      = owner_q;
    last_d       = last_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rd_data_d    = rd_data_q;
    winner       = OWN_A;
    a_gnt_d      = 1'b0;
    b_gnt_d      = 1'b0;
    a_rvalid_d   = 1'b0;
    b_rvalid_d   = 1'b0;
    en_store_d   = 1'b0;
    en_load_d    = 1'b0;
    addr_store_d = '0;
    addr_load_d  = '0;
    data_store_d = '0;
    busy_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (a_req || b_req) begin
          // On a tie, round-robin hands the port to whoever did not go last.
          if (a_req && b_req) winner = (RR != 0) ? ~last_q : OWN_A;
          else                winner = b_req ? OWN_B : OWN_A;
          owner_d = winner;
          last_d  = winner;
          we_d    = (winner == OWN_B) ? b_we    : a_we;
          addr_d  = (winner == OWN_B) ? b_addr  : a_addr;
          wdata_d = (winner == OWN_B) ? b_wdata : a_wdata;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (we_q) begin
          state_d = S_IDLE;
        end else if (LOAD_LAT == 0) begin
          rd_data_d = data_load;
          state_d   = S_RESP;
        end else begin
          lat_d   = LAT_INIT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (lat_q == 2'd0) begin
          rd_data_d = data_load;
          state_d   = S_RESP;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so decode them from the state being entered.
    busy_d = (state_d != S_IDLE);
    if (state_d == S_ISSUE) begin
      a_gnt_d = (owner_d == OWN_A);
      b_gnt_d = (owner_d == OWN_B);
      if (we_d) begin
        en_store_d   = 1'b1;
        addr_store_d = addr_d;
        data_store_d = wdata_d;
      end else begin
        en_load_d   = 1'b1;
        addr_load_d = addr_d;
      end
    end
    if (state_d == S_RESP) begin
      a_rvalid_d = (owner_d == OWN_A);
      b_rvalid_d = (owner_d == OWN_B);
    end
  end

  assign a_gnt      = a_gnt_q;
  assign b_gnt      = b_gnt_q;
  assign a_rvalid   = a_rvalid_q;
  assign b_rvalid   = b_rvalid_q;
  assign rd_data    = rd_data_q;
  assign en_store   = en_store_q;
  assign addr_store = addr_store_q;
  assign data_store = data_store_q;
  assign en_load    = en_load_q;
  assign addr_load  = addr_load_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_io_port_arbiter.sv
// Bench for io_port_arbiter: four instances share one stimulus stream.
// Instance g has LOAD_LAT = g; instance 2 uses fixed priority, the others
// round-robin. A timestamp-based model predicts every output each cycle.
module tb_io_port_arbiter;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 8;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [ADDR_W-1:0] a_addr = '0, b_addr = '0;
  logic [DATA_W-1:0] a_wdata = '0, b_wdata = '0, data_load = '0;

  logic              a_gnt [N], b_gnt [N], a_rvalid [N], b_rvalid [N];
  logic              en_store [N], en_load [N], busy [N];
  logic [DATA_W-1:0] rd_data [N], data_store [N];
  logic [ADDR_W-1:0] addr_store [N], addr_load [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    io_port_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOAD_LAT(g), .RR((g == 2) ? 0 : 1)
    ) u_dut (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_gnt(a_gnt[g]), .a_rvalid(a_rvalid[g]),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_gnt(b_gnt[g]), .b_rvalid(b_rvalid[g]),
      .rd_data(rd_data[g]),
      .en_store(en_store[g]), .addr_store(addr_store[g]), .data_store(data_store[g]),
      .en_load(en_load[g]), .addr_load(addr_load[g]), .data_load(data_load),
      .busy(busy[g])
    );
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(string name, int inst, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s inst%0d actual=%0h required=%0h t=%0t", name, inst, act, exp, $time);
    end
  endtask

  task automatic chk_str(string name, string act, string exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%s required=%s", name, act, exp);
    end
  endtask

  // Model: each instance is free once cycle index >= free_at. An access
  // sampled at edge k issues in cycle k; a load's RESP is cycle k+1+LAT.
  int                cyc = 0;
  int                free_at [N], issue_c [N], resp_c [N];
  bit                own_b [N], last_b [N], m_we [N];
  logic [ADDR_W-1:0] m_addr [N];
  logic [DATA_W-1:0] m_wdata [N], m_rd [N];

  function automatic void m_step(int i);
    bit win;
    if (rst) begin
      free_at[i] = 0; issue_c[i] = -1; resp_c[i] = -1;
      last_b[i] = 1'b1; m_rd[i] = '0;
      return;
    end
    if (cyc == resp_c[i]) m_rd[i] = data_load;
    if ((cyc - 1 >= free_at[i]) && (a_req || b_req)) begin
      if (a_req && b_req) win = (i == 2) ? 1'b0 : !last_b[i];
      else                win = b_req;
      own_b[i]   = win;
      last_b[i]  = win;
      m_we[i]    = win ? b_we    : a_we;
      m_addr[i]  = win ? b_addr  : a_addr;
      m_wdata[i] = win ? b_wdata : a_wdata;
      issue_c[i] = cyc;
      if (m_we[i]) begin
        resp_c[i]  = -1;
        free_at[i] = cyc + 1;
      end else begin
        resp_c[i]  = cyc + 1 + i;
        free_at[i] = cyc + 2 + i;
      end
    end
  endfunction

  task automatic m_cmp(int i);
    bit iss, rsp;
    iss = (cyc == issue_c[i]);
    rsp = (cyc == resp_c[i]);
    chk("a_gnt",      i, int'(a_gnt[i]),      int'(iss && !own_b[i]));
    chk("b_gnt",      i, int'(b_gnt[i]),      int'(iss && own_b[i]));
    chk("en_store",   i, int'(en_store[i]),   int'(iss && m_we[i]));
    chk("addr_store", i, int'(addr_store[i]), int'((iss && m_we[i]) ? m_addr[i] : '0));
    chk("data_store", i, int'(data_store[i]), int'((iss && m_we[i]) ? m_wdata[i] : '0));
    chk("en_load",    i, int'(en_load[i]),    int'(iss && !m_we[i]));
    chk("addr_load",  i, int'(addr_load[i]),  int'((iss && !m_we[i]) ? m_addr[i] : '0));
    chk("a_rvalid",   i, int'(a_rvalid[i]),   int'(rsp && !own_b[i]));
    chk("b_rvalid",   i, int'(b_rvalid[i]),   int'(rsp && own_b[i]));
    chk("busy",       i, int'(busy[i]),       int'(cyc < free_at[i]));
    chk("rd_data",    i, int'(rd_data[i]),    int'(m_rd[i]));
  endtask

  // Advance the model at each rising edge, compare just after it.
  initial forever begin
    @(posedge clk);
    cyc++;
    for (int i = 0; i < N; i++) m_step(i);
    #1;
    for (int i = 0; i < N; i++) m_cmp(i);
  end

  task automatic nclk(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(int n);
    a_req = 1'b0; b_req = 1'b0;
    nclk(n);
  endtask

  task automatic chk_zero(string name);
    for (int i = 0; i < N; i++) begin
      chk({name, "_gnt"},    i, int'(a_gnt[i] | b_gnt[i]), 0);
      chk({name, "_rvalid"}, i, int'(a_rvalid[i] | b_rvalid[i]), 0);
      chk({name, "_en"},     i, int'(en_store[i] | en_load[i]), 0);
      chk({name, "_addr"},   i, int'(addr_store[i] | addr_load[i]), 0);
      chk({name, "_dstore"}, i, int'(data_store[i]), 0);
      chk({name, "_rd"},     i, int'(rd_data[i]), 0);
      chk({name, "_busy"},   i, int'(busy[i]), 0);
    end
  endtask

  string s1, s2;
  int    rv0, rv3, seen;

  initial begin
    // Reset state.
    nclk(2);
    chk_zero("reset");
    rst = 1'b0;
    nclk(2);

    // Single store from A.
    a_req = 1'b1; a_we = 1'b1; a_addr = 10'h3FF; a_wdata = 8'hA5;
    nclk(1);
    chk("st_gnt",   1, int'(a_gnt[1]), 1);
    chk("st_en",    1, int'(en_store[1]), 1);
    chk("st_addr",  1, int'(addr_store[1]), 'h3FF);
    chk("st_data",  1, int'(data_store[1]), 'hA5);
    chk("st_busy",  1, int'(busy[1]), 1);
    chk("st_nold",  1, int'(en_load[1]), 0);
    a_req = 1'b0;
    nclk(1);
    chk("st_en_off",   1, int'(en_store[1]), 0);
    chk("st_addr_off", 1, int'(addr_store[1]), 0);
    chk("st_busy_off", 1, int'(busy[1]), 0);

    // Single load from B, LOAD_LAT=1.
    idle(3);
    b_req = 1'b1; b_we = 1'b0; b_addr = 10'h010; data_load = 8'h00;
    nclk(1);
    chk("ld_gnt",  1, int'(b_gnt[1]), 1);
    chk("ld_en",   1, int'(en_load[1]), 1);
    chk("ld_addr", 1, int'(addr_load[1]), 'h010);
    b_req = 1'b0; data_load = 8'h3C;
    nclk(1);
    chk("ld_wait_en", 1, int'(en_load[1]), 0);
    chk("ld_wait_rv", 1, int'(b_rvalid[1]), 0);
    nclk(1);
    chk("ld_rvalid",  1, int'(b_rvalid[1]), 1);
    chk("ld_rdata",   1, int'(rd_data[1]), 'h3C);
    chk("ld_a_rv",    1, int'(a_rvalid[1]), 0);
    data_load = 8'h55;
    nclk(1);
    chk("ld_rv_off",  1, int'(b_rvalid[1]), 0);
    chk("ld_hold",    1, int'(rd_data[1]), 'h3C);

    // Tie with both requesters storing continuously.
    idle(8);
    a_req = 1'b1; b_req = 1'b1; a_we = 1'b1; b_we = 1'b1;
    a_addr = 10'h001; b_addr = 10'h002;
    s1 = ""; s2 = "";
    repeat (8) begin
      nclk(1);
      if (a_gnt[1]) s1 = {s1, "A"};
      if (b_gnt[1]) s1 = {s1, "B"};
      if (a_gnt[2]) s2 = {s2, "A"};
      if (b_gnt[2]) s2 = {s2, "B"};
    end
    chk_str("rr_seq", s1, "ABAB");
    chk_str("fixed_seq", s2, "AAAA");
    a_req = 1'b0;
    nclk(1);
    chk("fixed_b_after", 2, int'(b_gnt[2]), 1);
    b_req = 1'b0;

    // LOAD_LAT=0 and LOAD_LAT=3 loads, then a store must not touch rd_data.
    idle(8);
    a_req = 1'b1; a_we = 1'b0; a_addr = 10'h100; data_load = 8'h7E;
    rv0 = -1; rv3 = -1;
    for (int c = 1; c <= 8; c++) begin
      nclk(1);
      if (c == 1) a_req = 1'b0;
      if (a_rvalid[0] && rv0 < 0) begin
        rv0 = c;
        chk("lat0_rd", 0, int'(rd_data[0]), 'h7E);
      end
      if (a_rvalid[3] && rv3 < 0) begin
        rv3 = c;
        chk("lat3_rd", 3, int'(rd_data[3]), 'h7E);
      end
    end
    chk("lat0_cycle", 0, rv0, 2);
    chk("lat3_cycle", 3, rv3, 5);
    a_req = 1'b1; a_we = 1'b1; a_addr = 10'h005; a_wdata = 8'h11; data_load = 8'h22;
    nclk(1);
    a_req = 1'b0;
    nclk(2);
    chk("st_keeps_rd", 0, int'(rd_data[0]), 'h7E);
    chk("st_keeps_rd", 3, int'(rd_data[3]), 'h7E);

    // Reset in the middle of a LOAD_LAT=2 load.
    idle(8);
    a_req = 1'b1; a_we = 1'b0; a_addr = 10'h005; data_load = 8'h99;
    nclk(1);
    a_req = 1'b0;
    nclk(1);
    chk("mid_busy", 2, int'(busy[2]), 1);
    rst = 1'b1;
    #1;
    chk_zero("rst_mid");
    nclk(2);
    rst = 1'b0;
    seen = 0;
    repeat (6) begin
      nclk(1);
      if (a_rvalid[2]) seen++;
    end
    chk("no_rv_after_rst", 2, seen, 0);
    a_req = 1'b1;
    nclk(1);
    a_req = 1'b0;
    nclk(3);
    chk("reload_rv", 2, int'(a_rvalid[2]), 1);
    chk("reload_rd", 2, int'(rd_data[2]), 'h99);

    // Random traffic, including occasional resets.
    repeat (3000) begin
      nclk(1);
      a_req     = ($urandom_range(0, 2) != 0);
      b_req     = ($urandom_range(0, 2) != 0);
      a_we      = 1'($urandom_range(0, 1));
      b_we      = 1'($urandom_range(0, 1));
      a_addr    = ADDR_W'($urandom);
      b_addr    = ADDR_W'($urandom);
      a_wdata   = DATA_W'($urandom);
      b_wdata   = DATA_W'($urandom);
      data_load = DATA_W'($urandom);
      rst       = ($urandom_range(0, 299) == 0);
    end
    rst = 1'b0;
    idle(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
